// File: rtl/mem_ctrl_if.sv
// mem_ctrl_if -- cache-side request/response bundle for mem_ctrl.
//   req_valid_in  : request valid (cache miss / write-back)
//   req_addr_in   : first byte address
//   req_data_in   : write data, little-endian
//   req_r_nw_in   : 1 read, 0 write
//   req_type_in   : [1:0] 00 word, 01 half, 10 byte, 11 word; [2] signed
//   req_ready_out : controller can accept a request
//   resp_valid_out: one-cycle completion pulse
//   resp_data_out : extended read data, 0 after writes
// master = request source (cache side), slave = mem_ctrl.
interface mem_ctrl_if;
  logic        req_valid_in;
  logic [31:0] req_addr_in;
  logic [31:0] req_data_in;
  logic        req_r_nw_in;
  logic [2:0]  req_type_in;
  logic        req_ready_out;
  logic        resp_valid_out;
  logic [31:0] resp_data_out;

  modport master (
    output req_valid_in, req_addr_in, req_data_in, req_r_nw_in, req_type_in,
    input  req_ready_out, resp_valid_out, resp_data_out
  );

  modport slave (
    input  req_valid_in, req_addr_in, req_data_in, req_r_nw_in, req_type_in,
    output req_ready_out, resp_valid_out, resp_data_out
  );
endinterface

// File: rtl/mem_ctrl.sv
// mem_ctrl -- serialises word/half/byte requests onto a byte-wide RAM port.
// Ports:
//   clk_in, rst_n_in : clock (rising edge), async active-low reset
//   rdy_in           : global pause when low (everything frozen)
//   req_if           : mem_ctrl_if.slave request/response bundle
//   mem_din          : RAM read byte, valid one cycle after mem_a
//   mem_dout, mem_a, mem_wr : RAM write byte, byte address, write strobe
//   io_buffer_full   : I/O sink full (only with MEM_CTRL_IO_STALL_EN)
// Optional feature: define MEM_CTRL_IO_STALL_EN to hold byte writes to I/O
// addresses (addr[IO_ADDR_BIT:IO_ADDR_BIT-1] == 2'b11) while the sink is full.
//
// state | meaning
// IDLE  | waiting for a request, req_ready_out high
// RD    | issuing read addresses and capturing bytes one cycle later
// WR    | writing one byte per cycle
// DONE  | response pulse, then back to IDLE
module mem_ctrl #(
  parameter int IO_ADDR_BIT = 17
) (
  input  logic        clk_in,
  input  logic        rst_n_in,
  input  logic        rdy_in,
  mem_ctrl_if.slave   req_if,
  input  logic [7:0]  mem_din,
  output logic [7:0]  mem_dout,
  output logic [31:0] mem_a,
  output logic        mem_wr
`ifdef MEM_CTRL_IO_STALL_EN
  ,
  input  logic        io_buffer_full
`endif
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2,
    DONE = 2'd3
  } state_e;

  state_e      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] data_q, data_d;
  logic [2:0]  type_q, type_d;
  logic        r_nw_q, r_nw_d;
  logic [31:0] rbuf_q, rbuf_d;
  logic [31:0] resp_data_q, resp_data_d;
  logic [31:0] mem_a_hold_q, mem_a_hold_d;
  logic        alive_q;

  logic [2:0]  n_bytes;
  logic [2:0]  a_idx;
  logic [1:0]  cap_idx;
  logic [31:0] byte_addr;
  logic        is_io;
  logic        wr_stall;
  logic        ready;
  logic        accept;

  function automatic logic [31:0] extend(input logic [31:0] w, input logic [2:0] t);
    logic [31:0] r;
    case (t[1:0])
      2'b01:   r = {{16{t[2] & w[15]}}, w[15:0]};
      2'b10:   r = {{24{t[2] & w[7]}}, w[7:0]};
      default: r = w;
    endcase
    return r;
  endfunction

  // alive_q keeps req_ready_out low until the first edge after reset release
  assign ready                 = alive_q && (state_q == IDLE);
  assign accept                = req_if.req_valid_in && ready && rdy_in;
  assign req_if.req_ready_out  = ready;
  assign req_if.resp_data_out  = resp_data_q;

  always_comb begin
    case (type_q[1:0])
      2'b01:   n_bytes = 3'd2;
      2'b10:   n_bytes = 3'd1;
      default: n_bytes = 3'd4;
    endcase
  end

  // In the final read cycle (cnt_q == n_bytes) no new address is issued;
  // the last one stays on the bus while its byte is captured.
  assign a_idx     = (state_q == RD && cnt_q == n_bytes) ? cnt_q - 3'd1 : cnt_q;
  assign cap_idx   = cnt_q[1:0] - 2'd1;
  assign byte_addr = addr_q + {29'd0, a_idx};
  assign is_io     = (byte_addr[IO_ADDR_BIT -: 2] == 2'b11);

`ifdef MEM_CTRL_IO_STALL_EN
  assign wr_stall = is_io & io_buffer_full;
`else
  // writes to I/O addresses are never held back in this build
  assign wr_stall = is_io & 1'b0;
`endif

  always_comb begin
    state_d               = state_q;
    cnt_d                 = cnt_q;
    addr_d                = addr_q;
    data_d                = data_q;
    type_d                = type_q;
    r_nw_d                = r_nw_q;
    rbuf_d                = rbuf_q;
    resp_data_d           = resp_data_q;
    req_if.resp_valid_out = 1'b0;
    mem_a                 = 32'd0;
    mem_dout              = 8'd0;
    mem_wr                = 1'b0;

    case (state_q)
      IDLE: begin
        if (accept) begin
          addr_d      = req_if.req_addr_in;
          data_d      = req_if.req_data_in;
          type_d      = req_if.req_type_in;
          r_nw_d      = req_if.req_r_nw_in;
          cnt_d       = 3'd0;
          rbuf_d      = 32'd0;
          resp_data_d = 32'd0;
          state_d     = req_if.req_r_nw_in ? RD : WR;
        end
      end
      RD: begin
        mem_a = byte_addr;
        if (rdy_in) begin
          if (cnt_q != 3'd0) begin
            rbuf_d[{cap_idx, 3'b000} +: 8] = mem_din;
          end
          if (cnt_q == n_bytes) begin
            resp_data_d = extend(rbuf_d, type_q);
            state_d     = DONE;
          end else begin
            cnt_d = cnt_q + 3'd1;
          end
        end
      end
      WR: begin
        mem_a    = byte_addr;
        mem_dout = data_q[{cnt_q[1:0], 3'b000} +: 8];
        if (rdy_in && !wr_stall) begin
          mem_wr = 1'b1;
          if (cnt_q == n_bytes - 3'd1) begin
            cnt_d   = 3'd0;
            state_d = DONE;
          end else begin
            cnt_d = cnt_q + 3'd1;
          end
        end
      end
      DONE: begin
        if (rdy_in) begin
          req_if.resp_valid_out = 1'b1;
          state_d               = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Holding the previous address while paused keeps mem_din pointing at
    // the byte the next active cycle expects to capture.
    if (!rdy_in) begin
      mem_a = mem_a_hold_q;
    end
    mem_a_hold_d = mem_a;
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q      <= IDLE;
      cnt_q        <= 3'd0;
      addr_q       <= 32'd0;
      data_q       <= 32'd0;
      type_q       <= 3'd0;
      r_nw_q       <= 1'b0;
      rbuf_q       <= 32'd0;
      resp_data_q  <= 32'd0;
      mem_a_hold_q <= 32'd0;
      alive_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      addr_q       <= addr_d;
      data_q       <= data_d;
      type_q       <= type_d;
      r_nw_q       <= r_nw_d;
      rbuf_q       <= rbuf_d;
      resp_data_q  <= resp_data_d;
      mem_a_hold_q <= mem_a_hold_d;
      alive_q      <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mem_ctrl.sv
module tb_mem_ctrl;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        rdy;
  logic [7:0]  mem_din;
  logic [7:0]  mem_dout;
  logic [31:0] mem_a;
  logic        mem_wr;
`ifdef MEM_CTRL_IO_STALL_EN
  logic        io_full;
`endif

  mem_ctrl_if bus();

  mem_ctrl dut (
    .clk_in   (clk),
    .rst_n_in (rst_n),
    .rdy_in   (rdy),
    .req_if   (bus),
    .mem_din  (mem_din),
    .mem_dout (mem_dout),
    .mem_a    (mem_a),
    .mem_wr   (mem_wr)
`ifdef MEM_CTRL_IO_STALL_EN
    ,
    .io_buffer_full (io_full)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [7:0]  d;
  } wr_t;

  int          tests = 0;
  int          fails = 0;
  logic [7:0]  ram [logic [31:0]];
  logic [31:0] last_a = 32'd0;
  wr_t         wq[$];
  int          wr_in_pause = 0;
  int          last_lat;
  logic [31:0] last_resp;

  function automatic logic [7:0] ram_rd(input logic [31:0] a);
    if (ram.exists(a)) return ram[a];
    return a[7:0] ^ a[23:16] ^ 8'hC3;
  endfunction

  function automatic int nbytes(input logic [2:0] t);
    if (t[1:0] == 2'b01) return 2;
    if (t[1:0] == 2'b10) return 1;
    return 4;
  endfunction

  function automatic logic [31:0] exp_read(input logic [31:0] addr, input logic [2:0] t);
    int n = nbytes(t);
    logic [31:0] v;
    logic [7:0]  b;
    v = 32'd0;
    for (int k = 0; k < n; k++) begin
      b = ram_rd(addr + 32'(k));
      v = v | (32'(b) << (8 * k));
    end
    if (t[2] && n < 4 && v[8*n-1]) v = v | (32'hFFFFFFFF << (8 * n));
    return v;
  endfunction

  // RAM model: bus sampled mid-cycle, read byte presented in the next cycle
  always @(negedge clk) begin
    last_a = mem_a;
    if (mem_wr) begin
      ram[mem_a] = mem_dout;
      wq.push_back('{mem_a, mem_dout});
      if (!rdy) wr_in_pause++;
    end
  end

  always @(posedge clk) begin
    #1 mem_din = ram_rd(last_a);
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready(output bit ok);
    int guard = 0;
    while (bus.req_ready_out !== 1'b1 && guard < 50) begin
      tick();
      guard++;
    end
    ok = (bus.req_ready_out === 1'b1);
  endtask

  task automatic drive_req(input logic [31:0] addr, input logic [31:0] data,
                           input logic rnw, input logic [2:0] t);
    bus.req_valid_in = 1'b1;
    bus.req_addr_in  = addr;
    bus.req_data_in  = data;
    bus.req_r_nw_in  = rnw;
    bus.req_type_in  = t;
  endtask

  task automatic scramble_req;
    bus.req_valid_in = 1'b0;
    bus.req_addr_in  = $urandom;
    bus.req_data_in  = $urandom;
    bus.req_r_nw_in  = 1'($urandom_range(1));
    bus.req_type_in  = 3'($urandom_range(7));
  endtask

  // One full transaction with rdy pauses (pmask bit c forces a pause in
  // cycle c after the accept edge; pct adds random pauses).
  task automatic xact(input logic [31:0] addr, input logic [31:0] data, input logic rnw,
                      input logic [2:0] t, input int pct, input logic [63:0] pmask,
                      input string name);
    int n, base, pauses, m, idx, a_err, w_err;
    logic [31:0] exp_d, prev_a;
    bit ok, seen, done_ready_err;
    n     = nbytes(t);
    base  = rnw ? n + 2 : n + 1;
    exp_d = rnw ? exp_read(addr, t) : 32'd0;
    rdy   = 1'b1;
    wait_ready(ok);
    tests++;
    if (!ok) begin
      fails++;
      $display("FAIL %s ready_wait: got %b, expected 1", name, bus.req_ready_out);
      return;
    end
    drive_req(addr, data, rnw, t);
    @(posedge clk);
    #1;
    scramble_req();
    wq.delete();
    pauses = 0; m = 0; idx = 0; a_err = 0; seen = 0; prev_a = 32'd0; done_ready_err = 0;
    for (int c = 1; c <= base + 40 && !seen; c++) begin
      rdy = ((c < 64 && pmask[c]) || ($urandom_range(99) < pct)) ? 1'b0 : 1'b1;
      @(negedge clk);
      if (rdy) begin
        idx++;
        if (idx <= n && mem_a !== addr + 32'(idx - 1)) a_err++;
      end else if (mem_a !== prev_a) begin
        a_err++;
      end
      if (bus.resp_valid_out === 1'b1) begin
        seen = 1; m = c;
        if (bus.req_ready_out !== 1'b0) done_ready_err = 1;
      end
      if (!rdy) pauses++;
      prev_a = mem_a;
      tick();
    end
    rdy = 1'b1;
    last_lat  = m;
    last_resp = bus.resp_data_out;

    tests++;
    if (!seen || m != base + pauses) begin
      fails++;
      $display("FAIL %s latency: got %0d, expected %0d", name, m, base + pauses);
    end
    tests++;
    if (bus.resp_data_out !== exp_d) begin
      fails++;
      $display("FAIL %s resp_data: got %h, expected %h", name, bus.resp_data_out, exp_d);
    end
    tests++;
    if (a_err != 0) begin
      fails++;
      $display("FAIL %s mem_a_seq: got %0d bad cycles, expected 0", name, a_err);
    end
    tests++;
    if (done_ready_err || bus.req_ready_out !== 1'b1) begin
      fails++;
      $display("FAIL %s ready_after: got done_err=%b idle=%b, expected 0/1",
               name, done_ready_err, bus.req_ready_out);
    end
    tests++;
    w_err = 0;
    if (rnw) begin
      if (wq.size() != 0) w_err++;
    end else if (wq.size() != n) begin
      w_err++;
    end else begin
      for (int k = 0; k < n; k++)
        if (wq[k].a !== addr + 32'(k) || wq[k].d !== data[8*k +: 8]) w_err++;
    end
    if (w_err != 0) begin
      fails++;
      $display("FAIL %s writes: got %0d writes (%0d bad), expected %0d", name, wq.size(), w_err,
               rnw ? 0 : n);
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    rdy   = 1'b1;
    mem_din = 8'd0;
    scramble_req();
    repeat (2) @(posedge clk);
    #1;
    tests++;
    if ({bus.req_ready_out, bus.resp_valid_out, mem_wr} !== 3'b000) begin
      fails++;
      $display("FAIL reset_ctrl: got ready/valid/wr=%b, expected 000",
               {bus.req_ready_out, bus.resp_valid_out, mem_wr});
    end
    tests++;
    if ({bus.resp_data_out, mem_a, mem_dout} !== 72'd0) begin
      fails++;
      $display("FAIL reset_data: got resp=%h a=%h dout=%h, expected 0", bus.resp_data_out,
               mem_a, mem_dout);
    end
    #2 rst_n = 1'b1;
    #1;
    tests++;
    if (bus.req_ready_out !== 1'b0) begin
      fails++;
      $display("FAIL reset_release_early: got ready=%b, expected 0", bus.req_ready_out);
    end
    tick();
    tests++;
    if (bus.req_ready_out !== 1'b1) begin
      fails++;
      $display("FAIL reset_release: got ready=%b, expected 1", bus.req_ready_out);
    end
  endtask

  task automatic test_directed;
    ram[32'h100] = 8'h11; ram[32'h101] = 8'h22; ram[32'h102] = 8'h33; ram[32'h103] = 8'h44;
    xact(32'h100, 32'd0, 1'b1, 3'b000, 0, 64'd0, "word_rd");
    tests++;
    if (last_resp !== 32'h44332211 || last_lat != 6) begin
      fails++;
      $display("FAIL word_rd_const: got %h @%0d, expected 44332211 @6", last_resp, last_lat);
    end
    ram[32'h205] = 8'h80;
    xact(32'h205, 32'd0, 1'b1, 3'b110, 0, 64'd0, "sbyte_rd");
    tests++;
    if (last_resp !== 32'hFFFFFF80 || last_lat != 3) begin
      fails++;
      $display("FAIL sbyte_const: got %h @%0d, expected ffffff80 @3", last_resp, last_lat);
    end
    xact(32'h205, 32'd0, 1'b1, 3'b010, 0, 64'd0, "ubyte_rd");
    tests++;
    if (last_resp !== 32'h00000080) begin
      fails++;
      $display("FAIL ubyte_const: got %h, expected 00000080", last_resp);
    end
    xact(32'h300, 32'hABCD1234, 1'b0, 3'b001, 0, 64'd0, "half_wr");
    tests++;
    if (wq.size() != 2 || wq[0].a !== 32'h300 || wq[0].d !== 8'h34 ||
        wq[1].a !== 32'h301 || wq[1].d !== 8'h12 || last_lat != 3 || last_resp !== 32'd0) begin
      fails++;
      $display("FAIL half_wr_const: got %0d writes @%0d resp=%h, expected 2 @3 resp=0",
               wq.size(), last_lat, last_resp);
    end
  endtask

  task automatic test_pause;
    ram[32'h600] = 8'hAA; ram[32'h601] = 8'hBB; ram[32'h602] = 8'hCC; ram[32'h603] = 8'hDD;
    // byte 1 address goes out in cycle 2; pause cycles 3..5
    xact(32'h600, 32'd0, 1'b1, 3'b000, 0, 64'h38, "pause_rd");
    tests++;
    if (last_resp !== 32'hDDCCBBAA || last_lat != 9) begin
      fails++;
      $display("FAIL pause_const: got %h @%0d, expected ddccbbaa @9", last_resp, last_lat);
    end
  endtask

  task automatic test_reset_mid;
    bit ok, bad_valid;
    rdy = 1'b1;
    wait_ready(ok);
    drive_req(32'h400, 32'h87654321, 1'b0, 3'b000);
    @(posedge clk);
    #1;
    scramble_req();
    wq.delete();
    tick();
    @(negedge clk);
    tests++;
    if (mem_wr !== 1'b1 || mem_a !== 32'h401) begin
      fails++;
      $display("FAIL midrst_byte2: got wr=%b a=%h, expected 1 401", mem_wr, mem_a);
    end
    #2 rst_n = 1'b0;
    #1;
    tests++;
    if (mem_wr !== 1'b0 || bus.req_ready_out !== 1'b0 || mem_a !== 32'd0) begin
      fails++;
      $display("FAIL midrst_async: got wr=%b ready=%b a=%h, expected 0 0 0", mem_wr,
               bus.req_ready_out, mem_a);
    end
    bad_valid = 0;
    repeat (2) begin
      @(negedge clk);
      if (bus.resp_valid_out !== 1'b0) bad_valid = 1;
    end
    @(posedge clk);
    #3 rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      if (bus.resp_valid_out !== 1'b0) bad_valid = 1;
    end
    tests++;
    if (bad_valid || wq.size() != 2 || bus.req_ready_out !== 1'b1) begin
      fails++;
      $display("FAIL midrst_abort: got resp=%b writes=%0d ready=%b, expected 0 2 1", bad_valid,
               wq.size(), bus.req_ready_out);
    end
    tick();
  endtask

  task automatic test_back_to_back;
    bit ok;
    logic [6:0] rv, rd_v;
    rdy = 1'b1;
    wait_ready(ok);
    rv = '0; rd_v = '0;
    drive_req(32'h500, 32'h0000005C, 1'b0, 3'b010);
    wq.delete();
    @(posedge clk);
    #1;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      rv[c]   = bus.resp_valid_out;
      rd_v[c] = bus.req_ready_out;
      tick();
      if (c == 5) scramble_req();
    end
    tests++;
    if (rv !== 7'b0100100 || rd_v !== 7'b1001000 || wq.size() != 2) begin
      fails++;
      $display("FAIL back_to_back: got valid=%b ready=%b writes=%0d, expected 0100100 1001000 2",
               rv, rd_v, wq.size());
    end
  endtask

  task automatic test_random;
    logic [31:0] addr;
    for (int i = 0; i < 40; i++) begin
      addr = ($urandom_range(3) == 0) ? 32'hFFFFFFFC + 32'($urandom_range(3)) : $urandom;
      xact(addr, $urandom, 1'($urandom_range(1)), 3'($urandom_range(7)), 20, 64'd0, "random");
    end
    tests++;
    if (wr_in_pause != 0) begin
      fails++;
      $display("FAIL wr_in_pause: got %0d, expected 0", wr_in_pause);
    end
  endtask

`ifdef MEM_CTRL_IO_STALL_EN
  task automatic test_io_stall;
    bit ok;
    logic [7:0] wv, rv;
    rdy = 1'b1;
    wait_ready(ok);
    wv = '0; rv = '0;
    io_full = 1'b1;
    drive_req(32'h30000, 32'h0000005A, 1'b0, 3'b010);
    @(posedge clk);
    #1;
    scramble_req();
    wq.delete();
    for (int c = 1; c <= 7; c++) begin
      io_full = (c <= 4);
      @(negedge clk);
      wv[c] = mem_wr;
      rv[c] = bus.resp_valid_out;
      tick();
    end
    tests++;
    if (wv !== 8'b00100000 || rv !== 8'b01000000 || wq.size() != 1 || wq[0].d !== 8'h5A) begin
      fails++;
      $display("FAIL io_stall: got wr=%b valid=%b writes=%0d, expected 00100000 01000000 1",
               wv, rv, wq.size());
    end
  endtask
`endif

  initial begin
`ifdef MEM_CTRL_IO_STALL_EN
    io_full = 1'b0;
`endif
    test_reset();
    test_directed();
    test_pause();
    test_back_to_back();
    test_reset_mid();
    test_random();
`ifdef MEM_CTRL_IO_STALL_EN
    test_io_stall();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mem_ctrl.md
MEM_CTRL -- requirements
Module: mem_ctrl

Interface
REQ-001 SHALL have parameter IO_ADDR_BIT, default 17: addresses with addr[IO_ADDR_BIT:IO_ADDR_BIT-1]==2'b11 are I/O.
REQ-002 SHALL have port clk_in, input, 1: single clock, all state updates on rising edge.
REQ-003 SHALL have port rst_n_in, input, 1: reset, asynchronous and active-low.
REQ-004 SHALL have port rdy_in, input, 1: global pause when low.
REQ-005 SHALL have port req_valid_in, input, 1: cache-side miss/write-back request valid.
REQ-006 SHALL have port req_addr_in, input, 32: first byte address.
REQ-007 SHALL have port req_data_in, input, 32: write data, little-endian.
REQ-008 SHALL have port req_r_nw_in, input, 1: 1 read, 0 write.
REQ-009 SHALL have port req_type_in, input, 3: [1:0] 00 word, 01 half, 10 byte, 11 treated as word; [2] 1 signed, 0 unsigned.
REQ-010 SHALL have port req_ready_out, output, 1: high only in IDLE.
REQ-011 SHALL have port resp_valid_out, output, 1: one-cycle completion pulse.
REQ-012 SHALL have port resp_data_out, output, 32: extended read data; 0 for writes.
REQ-013 SHALL have port mem_din, input, 8: RAM read byte, valid one cycle after mem_a.
REQ-014 SHALL have port mem_dout, output, 8: RAM write byte.
REQ-015 SHALL have port mem_a, output, 32: RAM byte address.
REQ-016 SHALL have port mem_wr, output, 1: RAM write strobe.
REQ-017 SHALL have port io_buffer_full, input, 1: I/O sink full; present only with MEM_CTRL_IO_STALL_EN.

Function
REQ-018 SHALL use states IDLE, RD, WR, DONE; n = 4/2/1 bytes for word/half/byte.
REQ-019 SHALL accept a request on an edge with req_valid_in && req_ready_out && rdy_in, latching addr, data, type, r_nw; next state RD or WR.
REQ-020 In RD, SHALL drive mem_a = addr+k, mem_wr=0, for k=0..n-1 in consecutive cycles, capturing mem_din as byte k one cycle later.
REQ-021 SHALL assert resp_valid_out exactly n+2 cycles after the accept edge for reads (last capture, then DONE).
REQ-022 In WR, SHALL drive mem_a = addr+k, mem_dout = data[8k+7:8k], mem_wr=1 for k=0..n-1, one byte per cycle.
REQ-023 SHALL assert resp_valid_out exactly n+1 cycles after the accept edge for writes.
REQ-024 SHALL sign-extend (type[2]=1) or zero-extend half/byte reads into resp_data_out; resp_data_out held until next accept.
REQ-025 SHALL perform no alignment check; addr+k is 32-bit wrap-around (0xFFFFFFFF+1 = 0).
REQ-026 SHALL return DONE -> IDLE after one cycle; req_ready_out is low in DONE, so back-to-back accept occurs no earlier than the cycle after resp_valid_out.
REQ-027 When idle, SHALL drive mem_wr=0, mem_a=0, mem_dout=0.
REQ-028 While rdy_in=0, SHALL freeze all state and counters, force mem_wr=0, hold mem_a, and suppress resp_valid_out; resume exactly where paused.
REQ-029 SHALL ignore req_valid_in outside IDLE; req_* inputs need not be held after accept.

Reset
REQ-030 On rst_n_in low, SHALL immediately enter IDLE and clear the byte counter and all latched data.
REQ-031 During reset, SHALL drive req_ready_out=0, resp_valid_out=0, resp_data_out=0, mem_wr=0, mem_a=0, mem_dout=0; req_ready_out rises the first cycle after release.
REQ-032 Reset mid-transfer SHALL abort without a response or further mem_wr.

Configuration
REQ-033 With MEM_CTRL_IO_STALL_EN defined, a WR byte to an I/O address while io_buffer_full=1 SHALL hold mem_wr=0 and not advance k until io_buffer_full=0.
REQ-034 Without MEM_CTRL_IO_STALL_EN, the io_buffer_full port SHALL be absent and all writes advance unconditionally.

Verification
REQ-035 Word read addr 0x100, RAM bytes 11,22,33,44 -> mem_a 0x100..0x103, resp_valid_out at accept+6, resp_data_out=0x44332211.
REQ-036 Signed byte read of 0x80 at 0x205 -> resp_data_out=0xFFFFFF80; unsigned -> 0x00000080; resp_valid_out at accept+3.
REQ-037 Half write 0xABCD1234 at 0x300 -> mem_wr cycles {0x300:0x34},{0x301:0x12}, resp_valid_out at accept+3, resp_data_out=0.
REQ-038 Word read with rdy_in low for 3 cycles after byte 1 -> same data, resp_valid_out delayed by exactly 3 cycles.
REQ-039 rst_n_in low during byte 2 of a word write -> no resp_valid_out, mem_wr=0 asynchronously, req_ready_out=1 the cycle after release.
REQ-040 With MEM_CTRL_IO_STALL_EN, byte write to 0x30000 with io_buffer_full high for 4 cycles -> mem_wr held low 4 cycles, then one write, resp_valid_out at accept+6.
